// File: rtl/sd_spi_pkg.sv
// ---------------------------------------------------------------------------
// sd_spi_pkg
// Shared constants, error codes, FSM state encoding and small helpers for
// the SPI-mode SD single-block (CMD17) reader.
// ---------------------------------------------------------------------------
package sd_spi_pkg;

    localparam logic [7:0] CMD17_BYTE   = 8'h51;  // start bit + transmission bit + index 17
    localparam logic [7:0] DATA_TOKEN   = 8'hFE;  // start-of-block token for single reads
    localparam logic [7:0] DUMMY_BYTE   = 8'hFF;  // keeps DI high while clocking the card
    localparam int         SECTOR_BYTES = 512;
    localparam int         CMD_BYTES    = 6;
    localparam int         CRC_BYTES    = 2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_R1    = 2'd1;
    localparam logic [1:0] ERR_R1_TO = 2'd2;
    localparam logic [1:0] ERR_TOKEN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_CMD   = 3'd1,
        ST_WAIT_R1    = 3'd2,
        ST_WAIT_TOKEN = 3'd3,
        ST_READ_DATA  = 3'd4,
        ST_READ_CRC   = 3'd5,
        ST_TRAIL      = 3'd6,
        ST_DONE       = 3'd7
    } rd_state_t;

    // A data error token has the upper nibble clear (0x0X).
    function automatic logic is_error_token(input logic [7:0] rx);
        return (rx[7:4] == 4'h0);
    endfunction

    // Byte idx of the CMD17 frame: command, 4 address bytes MSB first, then a
    // dummy CRC byte (CRC is not checked by the card in SPI mode).
    function automatic logic [7:0] cmd17_byte(input logic [2:0] idx, input logic [31:0] addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD17_BYTE;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            default: b = DUMMY_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte_xfer.sv
// ---------------------------------------------------------------------------
// sd_spi_byte_xfer
// Full-duplex one-byte SPI mode-0 shifter with its own SCK divider. SCK idles
// low and toggles every CLK_DIV/2 clk_sd cycles while a byte is in flight.
// MOSI changes on SCK falling edges (first bit presented at start), MISO is
// sampled on SCK rising edges, MSB first. CS is a registered copy of
// i_cs_hold so the pin follows the controller one cycle later.
// Ports:
//   clk_sd, reset_n  clock, asynchronous active-low reset
//   i_start          begin a byte (ignored while busy)
//   i_abort          drop the byte in flight, SCK low, MOSI high
//   i_tx_byte        byte to shift out, sampled with i_start
//   i_cs_hold        1 keeps CS low
//   i_miso           card DO
//   o_sck/o_mosi/o_cs_n  SPI pins
//   o_busy           byte in flight
//   o_done           1-cycle pulse after the 8th falling edge
//   o_rx_byte        received byte, valid with o_done
// ---------------------------------------------------------------------------
module sd_spi_byte_xfer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sd,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_tx_byte,
    input  logic       i_cs_hold,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rx_byte
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_tx_sh;
    logic [7:0]       r_rx_sh;
    logic             r_sck;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_busy;
    logic             r_done;

    // CS follows the controller's hold request one cycle later.
    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n <= 1'b1;
        end else begin
            r_cs_n <= ~i_cs_hold;
        end
    end

    // Divider, bit shifter and SCK generation for one byte.
    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) begin
            r_div     <= '0;
            r_bit_cnt <= 3'd0;
            r_tx_sh   <= 8'hFF;
            r_rx_sh   <= 8'h00;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_div     <= '0;
                r_bit_cnt <= 3'd0;
                r_sck     <= 1'b0;
                r_mosi    <= 1'b1;
                r_busy    <= 1'b0;
            end else if (!r_busy) begin
                if (i_start) begin
                    // MSB must be on the wire before the first rising edge.
                    r_busy    <= 1'b1;
                    r_mosi    <= i_tx_byte[7];
                    r_tx_sh   <= {i_tx_byte[6:0], 1'b1};
                    r_div     <= '0;
                    r_bit_cnt <= 3'd0;
                end else begin
                    r_mosi <= 1'b1;
                end
            end else if (r_div == DIV_W'(HALF - 1)) begin
                r_div <= '0;
                r_sck <= ~r_sck;
                if (!r_sck) begin
                    r_rx_sh <= {r_rx_sh[6:0], i_miso};
                end else if (r_bit_cnt == 3'd7) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_mosi <= 1'b1;
                end else begin
                    r_mosi    <= r_tx_sh[7];
                    r_tx_sh   <= {r_tx_sh[6:0], 1'b1};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_sck     = r_sck;
    assign o_mosi    = r_mosi;
    assign o_cs_n    = r_cs_n;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_byte = r_rx_sh;

endmodule

// File: rtl/sd_spi_block_reader.sv
// ---------------------------------------------------------------------------
// sd_spi_block_reader
// Reads one 512-byte sector from an initialised SPI-mode SDHC card with CMD17
// and streams it out one byte per rd_data_valid strobe.
// Ports:
//   clk_sd, reset_n      clock, asynchronous active-low reset
//   i_sd_init_done       card is initialised (level); dropping it aborts a read
//   i_rd_start           1-cycle request, accepted in IDLE with init done
//   i_rd_addr            sector address, latched on accept
//   i_sd_spi_miso        card DO
//   o_sd_spi_clk/cs/mosi SPI pins (SCK idles low, CS active low, MOSI idles high)
//   o_rd_busy            read in progress
//   o_rd_data            sector byte, valid with o_rd_data_valid
//   o_rd_data_valid      1-cycle strobe per byte
//   o_rd_done            1-cycle pulse at the end of every accepted read
//   o_rd_err_code        0 ok, 1 R1 error, 2 R1 timeout, 3 token timeout/error/abort
// ---------------------------------------------------------------------------
module sd_spi_block_reader
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 50000
) (
    input  logic        clk_sd,
    input  logic        reset_n,
    input  logic        i_sd_init_done,
    input  logic        i_rd_start,
    input  logic [31:0] i_rd_addr,
    input  logic        i_sd_spi_miso,
    output logic        o_sd_spi_clk,
    output logic        o_sd_spi_cs,
    output logic        o_sd_spi_mosi,
    output logic        o_rd_busy,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_data_valid,
    output logic        o_rd_done,
    output logic [1:0]  o_rd_err_code
);

    localparam int CNT_W = 16;

    rd_state_t        r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [8:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0]      r_addr,   w_addr_nxt;
    logic [1:0]       r_err,    w_err_nxt;
    logic [7:0]       r_data,   w_data_nxt;
    logic             r_valid,  w_valid_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_busy,   w_busy_nxt;

    logic             w_start;
    logic             w_abort;
    logic [7:0]       w_tx_byte;
    logic             w_active;
    logic             w_xfer_state;
    logic             w_cs_hold;
    logic             w_xfer_busy;
    logic             w_xfer_done;
    logic [7:0]       w_rx_byte;
    logic             w_cs_n;

    // CS is held low from the command through the CRC bytes.
    assign w_active     = (r_state == ST_SEND_CMD)   || (r_state == ST_WAIT_R1)   ||
                          (r_state == ST_WAIT_TOKEN) || (r_state == ST_READ_DATA) ||
                          (r_state == ST_READ_CRC);
    assign w_xfer_state = w_active || (r_state == ST_TRAIL);
    assign w_cs_hold    = w_active && !w_abort;

    sd_spi_byte_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk_sd    (clk_sd),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_abort   (w_abort),
        .i_tx_byte (w_tx_byte),
        .i_cs_hold (w_cs_hold),
        .i_miso    (i_sd_spi_miso),
        .o_sck     (o_sd_spi_clk),
        .o_mosi    (o_sd_spi_mosi),
        .o_cs_n    (w_cs_n),
        .o_busy    (w_xfer_busy),
        .o_done    (w_xfer_done),
        .o_rx_byte (w_rx_byte)
    );

    // State and datapath registers.
    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= 9'd0;
            r_addr     <= 32'd0;
            r_err      <= ERR_NONE;
            r_data     <= 8'd0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_err      <= w_err_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state, byte sequencing and response decoding.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_addr_nxt     = r_addr;
        w_err_nxt      = r_err;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_tx_byte      = DUMMY_BYTE;
        w_abort        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_rd_start && i_sd_init_done) begin
                    w_addr_nxt     = i_rd_addr;
                    w_err_nxt      = ERR_NONE;
                    w_cnt_nxt      = '0;
                    w_byte_cnt_nxt = 9'd0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_SEND_CMD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND_CMD: begin
                w_tx_byte = cmd17_byte(r_cnt[2:0], r_addr);
                if (w_xfer_done) begin
                    if (r_cnt == CNT_W'(CMD_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT_R1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_WAIT_R1: begin
                // Bytes with MSB set are "still busy"; the first MSB=0 byte is R1.
                if (w_xfer_done) begin
                    if (!w_rx_byte[7]) begin
                        w_cnt_nxt = '0;
                        if (w_rx_byte == 8'h00) begin
                            w_state_nxt = ST_WAIT_TOKEN;
                        end else begin
                            w_err_nxt   = ERR_R1;
                            w_state_nxt = ST_TRAIL;
                        end
                    end else if (r_cnt == CNT_W'(R1_TIMEOUT - 1)) begin
                        w_err_nxt   = ERR_R1_TO;
                        w_state_nxt = ST_TRAIL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_WAIT_TOKEN: begin
                if (w_xfer_done) begin
                    if (w_rx_byte == DATA_TOKEN) begin
                        w_byte_cnt_nxt = 9'd0;
                        w_state_nxt    = ST_READ_DATA;
                    end else if (is_error_token(w_rx_byte) ||
                                 (r_cnt == CNT_W'(TOKEN_TIMEOUT - 1))) begin
                        w_err_nxt   = ERR_TOKEN;
                        w_state_nxt = ST_TRAIL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_READ_DATA: begin
                if (w_xfer_done) begin
                    w_data_nxt     = w_rx_byte;
                    w_valid_nxt    = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 9'd1;
                    if (r_byte_cnt == 9'(SECTOR_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_READ_CRC;
                    end else begin
                        w_state_nxt = ST_READ_DATA;
                    end
                end else begin
                    w_byte_cnt_nxt = r_byte_cnt;
                end
            end
            ST_READ_CRC: begin
                if (w_xfer_done) begin
                    if (r_cnt == CNT_W'(CRC_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_TRAIL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_TRAIL: begin
                // One dummy byte with CS high lets the card release DO.
                if (w_xfer_done) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_TRAIL;
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Losing the card mid-transaction cuts the byte short and still reports.
        if (w_active && !i_sd_init_done) begin
            w_abort     = 1'b1;
            w_valid_nxt = 1'b0;
            w_err_nxt   = ERR_TOKEN;
            w_state_nxt = ST_TRAIL;
        end else begin
            w_abort = 1'b0;
        end
    end

    // A new byte starts once the previous one has been consumed by the FSM.
    assign w_start = w_xfer_state && !w_xfer_busy && !w_xfer_done && !w_abort;

    assign o_sd_spi_cs     = w_cs_n;
    assign o_rd_busy       = r_busy;
    assign o_rd_data       = r_data;
    assign o_rd_data_valid = r_valid;
    assign o_rd_done       = r_done;
    assign o_rd_err_code   = r_err;

endmodule

// File: tb/tb_sd_spi_block_reader.sv
module tb_sd_spi_block_reader;

    localparam int T_R1  = 8;
    localparam int T_TOK = 64;

    logic        clk_sd = 1'b0;
    logic        reset_n;
    logic        init_done;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic        miso_r = 1'b1;
    logic        o_sd_spi_clk, o_sd_spi_cs, o_sd_spi_mosi;
    logic        o_rd_busy, o_rd_data_valid, o_rd_done;
    logic [7:0]  o_rd_data;
    logic [1:0]  o_rd_err_code;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;

    logic [7:0] exp_data_q[$];
    logic [1:0] exp_err_q[$];
    logic [7:0] sector_q[$];
    logic [7:0] card_q[$];
    logic [7:0] mosi_log[$];

    sd_spi_block_reader #(
        .CLK_DIV       (4),
        .R1_TIMEOUT    (T_R1),
        .TOKEN_TIMEOUT (T_TOK)
    ) dut (
        .clk_sd          (clk_sd),
        .reset_n         (reset_n),
        .i_sd_init_done  (init_done),
        .i_rd_start      (rd_start),
        .i_rd_addr       (rd_addr),
        .i_sd_spi_miso   (miso_r),
        .o_sd_spi_clk    (o_sd_spi_clk),
        .o_sd_spi_cs     (o_sd_spi_cs),
        .o_sd_spi_mosi   (o_sd_spi_mosi),
        .o_rd_busy       (o_rd_busy),
        .o_rd_data       (o_rd_data),
        .o_rd_data_valid (o_rd_data_valid),
        .o_rd_done       (o_rd_done),
        .o_rd_err_code   (o_rd_err_code)
    );

    always #10 clk_sd = ~clk_sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- card model (SPI mode 0 slave, byte scripted) ----------
    logic [7:0] card_sh = 8'hFF;
    logic [7:0] mosi_sh = 8'h00;
    int         bc = 0;

    function automatic logic [7:0] card_next();
        if (card_q.size() > 0) return card_q.pop_front();
        return 8'hFF;
    endfunction

    always @(negedge o_sd_spi_cs) begin
        bc      = 0;
        card_sh = card_next();
        miso_r  = card_sh[7];
    end

    always @(posedge o_sd_spi_cs) miso_r = 1'b1;

    always @(posedge o_sd_spi_clk) begin
        if (!o_sd_spi_cs) begin
            mosi_sh = {mosi_sh[6:0], o_sd_spi_mosi};
            bc++;
        end
    end

    always @(negedge o_sd_spi_clk) begin
        if (!o_sd_spi_cs) begin
            if (bc >= 8) begin
                mosi_log.push_back(mosi_sh);
                bc      = 0;
                card_sh = card_next();
                miso_r  = card_sh[7];
            end else begin
                miso_r = card_sh[7 - bc];
            end
        end
    end

    // ---------------- scoreboard monitor -----------------------------------
    always @(negedge clk_sd) begin
        if (reset_n === 1'b1) begin
            if (o_rd_data_valid) begin
                strobe_cnt++;
                check("byte_expected", 32'(exp_data_q.size() != 0), 32'd1);
                if (exp_data_q.size() != 0) check("rd_data", o_rd_data, exp_data_q.pop_front());
            end
            if (o_rd_done) begin
                done_cnt++;
                check("done_expected", 32'(exp_err_q.size() != 0), 32'd1);
                if (exp_err_q.size() != 0) check("rd_err_code", o_rd_err_code, exp_err_q.pop_front());
                check("busy_at_done", o_rd_busy, 32'd0);
                check("cs_at_done", o_sd_spi_cs, 32'd1);
            end
        end
    end

    // ---------------- reference model --------------------------------------
    // r1 < 0 means the card never answers the command.
    function automatic int model_err(int r1_gap, int r1, int tok_gap, int tok);
        if (r1 < 0 || r1_gap >= T_R1) return 2;
        if (r1 != 0) return 1;
        if (tok_gap >= T_TOK) return 3;
        if (tok == 'hFE) return 0;
        return 3;
    endfunction

    task automatic fill_sector(input bit counting);
        sector_q.delete();
        for (int i = 0; i < 512; i++)
            sector_q.push_back(counting ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    task automatic setup_card(input int r1_gap, input int r1, input int tok_gap, input int tok);
        card_q.delete();
        repeat (6 + r1_gap) card_q.push_back(8'hFF);
        if (r1 >= 0) begin
            card_q.push_back(8'(r1));
            if (r1 == 0) begin
                repeat (tok_gap) card_q.push_back(8'hFF);
                card_q.push_back(8'(tok));
                foreach (sector_q[i]) card_q.push_back(sector_q[i]);
                card_q.push_back(8'($urandom_range(0, 255)));
                card_q.push_back(8'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(negedge clk_sd);
        rd_addr  = addr;
        rd_start = 1'b1;
        @(negedge clk_sd);
        rd_start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input int err, input int nbytes);
        for (int i = 0; i < nbytes; i++) exp_data_q.push_back(sector_q[i]);
        exp_err_q.push_back(2'(err));
        mosi_log.delete();
        pulse_start(addr);
        check("busy_after_accept", o_rd_busy, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 40000) begin
            @(negedge clk_sd); #1;
            n++;
        end
        check("done_count", done_cnt, target);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobe_cnt < target && n < 40000) begin
            @(negedge clk_sd); #1;
            n++;
        end
        check("strobe_count", strobe_cnt, target);
    endtask

    task automatic check_cmd(input logic [31:0] addr);
        logic [7:0] exp_cmd[6];
        int nonff = 0;
        exp_cmd[0] = 8'h51;
        exp_cmd[1] = addr[31:24];
        exp_cmd[2] = addr[23:16];
        exp_cmd[3] = addr[15:8];
        exp_cmd[4] = addr[7:0];
        exp_cmd[5] = 8'hFF;
        while (mosi_log.size() < 6) mosi_log.push_back(8'hxx);
        for (int i = 0; i < 6; i++) check($sformatf("mosi_cmd%0d", i), mosi_log[i], exp_cmd[i]);
        for (int i = 6; i < mosi_log.size(); i++) if (mosi_log[i] !== 8'hFF) nonff++;
        check("mosi_dummy_bytes", nonff, 32'd0);
    endtask

    task automatic settle();
        repeat (60) @(negedge clk_sd);
        #1;
        check("data_queue_drained", exp_data_q.size(), 32'd0);
        check("err_queue_drained", exp_err_q.size(), 32'd0);
    endtask

    task automatic run_read(input logic [31:0] addr, input int r1_gap, input int r1,
                            input int tok_gap, input int tok);
        int err;
        int d0;
        err = model_err(r1_gap, r1, tok_gap, tok);
        setup_card(r1_gap, r1, tok_gap, tok);
        d0 = done_cnt;
        issue(addr, err, (err == 0) ? 512 : 0);
        wait_done(d0 + 1);
        check_cmd(addr);
        settle();
    endtask

    initial begin
        int d0, s0, busy_seen;
        logic [31:0] a;
        reset_n   = 1'b0;
        init_done = 1'b0;
        rd_start  = 1'b0;
        rd_addr   = 32'd0;
        repeat (3) @(negedge clk_sd);
        check("rst_sck", o_sd_spi_clk, 32'd0);
        check("rst_cs", o_sd_spi_cs, 32'd1);
        check("rst_mosi", o_sd_spi_mosi, 32'd1);
        check("rst_busy", o_rd_busy, 32'd0);
        check("rst_data", o_rd_data, 32'd0);
        check("rst_valid", o_rd_data_valid, 32'd0);
        check("rst_done", o_rd_done, 32'd0);
        check("rst_err", o_rd_err_code, 32'd0);
        reset_n   = 1'b1;
        init_done = 1'b1;
        repeat (3) @(negedge clk_sd);

        // Normal read, counting pattern, token after three 0xFF.
        fill_sector(1'b1);
        run_read(32'h0000_0010, 0, 8'h00, 3, 8'hFE);

        // Illegal command R1, then card that never answers.
        run_read($urandom, 1, 8'h04, 0, 8'hFE);
        run_read($urandom, 0, -1, 0, 8'hFE);
        // R1 on the last allowed poll, then one poll too late.
        run_read($urandom, T_R1 - 1, 8'h04, 0, 8'hFE);
        run_read($urandom, T_R1, 8'h00, 0, 8'hFE);

        // Error token; a second request while busy must be ignored.
        a = $urandom;
        setup_card(0, 8'h00, 20, 8'h08);
        d0 = done_cnt;
        issue(a, model_err(0, 0, 20, 8'h08), 0);
        repeat (150) @(negedge clk_sd);
        pulse_start(~a);
        wait_done(d0 + 1);
        check_cmd(a);
        settle();
        check("single_done_when_restarted", done_cnt - d0, 32'd1);

        // Request without init done: no response at all.
        init_done = 1'b0;
        d0 = done_cnt;
        busy_seen = 0;
        pulse_start($urandom);
        repeat (100) begin
            @(negedge clk_sd);
            if (o_rd_busy || !o_sd_spi_cs) busy_seen++;
        end
        check("no_busy_without_init", busy_seen, 32'd0);
        check("no_done_without_init", done_cnt - d0, 32'd0);
        init_done = 1'b1;

        // Token timeout.
        run_read($urandom, 2, 8'h00, T_TOK, 8'hFE);

        // Randomised error scenarios.
        for (int k = 0; k < 4; k++) begin
            int g, p, r1v, tg, tk;
            g   = $urandom_range(0, 9);
            p   = $urandom_range(0, 2);
            r1v = (p == 0) ? 0 : (p == 1) ? int'($urandom_range(1, 127)) : -1;
            tg  = $urandom_range(0, 10);
            tk  = $urandom_range(0, 15);
            run_read($urandom, g, r1v, tg, tk);
        end

        // init done dropped after 100 data bytes.
        fill_sector(1'b0);
        a = $urandom;
        setup_card(0, 8'h00, 1, 8'hFE);
        d0 = done_cnt;
        s0 = strobe_cnt;
        issue(a, 3, 100);
        wait_strobes(s0 + 100);
        init_done = 1'b0;
        wait_done(d0 + 1);
        init_done = 1'b1;
        settle();
        check("strobes_before_abort", strobe_cnt - s0, 32'd100);

        // Reset in the middle of the sector.
        fill_sector(1'b1);
        setup_card(0, 8'h00, 3, 8'hFE);
        d0 = done_cnt;
        s0 = strobe_cnt;
        issue(32'h0000_0020, 0, 512);
        wait_strobes(s0 + 200);
        reset_n = 1'b0;
        #1;
        check("midrst_cs", o_sd_spi_cs, 32'd1);
        check("midrst_sck", o_sd_spi_clk, 32'd0);
        check("midrst_busy", o_rd_busy, 32'd0);
        check("midrst_valid", o_rd_data_valid, 32'd0);
        exp_data_q.delete();
        exp_err_q.delete();
        repeat (5) @(negedge clk_sd);
        reset_n = 1'b1;
        repeat (300) @(negedge clk_sd);
        check("no_done_after_reset", done_cnt - d0, 32'd0);

        // Next read passes, with R1 and token each on their last allowed poll.
        fill_sector(1'b0);
        run_read($urandom, T_R1 - 1, 8'h00, T_TOK - 1, 8'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
